dmem_responder: RTL and testbench

- Target side of the core's data-memory interface: services core loads and stores against a word RAM and a small memory-mapped peripheral page.
- The page holds a console transmit FIFO with a valid/ready drain port, a free-running cycle counter, and status/error reporting.
- Sits beside the core at top level; its load-data output feeds the core's load-data input directly.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core data-memory bus plus console drain stream, seen from the responder (slave)
// and from the core/console side (master).
interface dmem_responder_if;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  modport slave (
    input  data_ce_i, data_we_i, data_addr_i, data_i, tx_ready_i,
    output data_o, tx_data_o, tx_valid_o
  );

  modport master (
    output data_ce_i, data_we_i, data_addr_i, data_i, tx_ready_i,
    input  data_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target: word RAM plus an MMIO page with a console TX FIFO,
// a free-running cycle counter, a status word and a sticky bad-access flag.
module dmem_responder #(
  parameter int         RAM_WORDS   = 1024,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] MMIO_NIBBLE = 4'h8
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus,
  output logic             err_o
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 5;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_drop;
  logic [31:0]   r_cycle;
  logic          r_err;

  logic          w_mmio, w_ram_oor, w_page_ok, w_rd, w_wr, w_bad;
  logic          w_sel_tx, w_sel_st, w_sel_cy;
  logic          w_full, w_empty, w_pop, w_push_req, w_push, w_drop;
  logic [5:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  assign w_mmio    = bus.data_addr_i[31:28] == MMIO_NIBBLE;
  assign w_ram_oor = |bus.data_addr_i[27:AW+2];
  assign w_page_ok = bus.data_addr_i[27:8] == 20'd0;
  assign w_off     = bus.data_addr_i[7:2];
  assign w_idx     = bus.data_addr_i[AW+1:2];
  assign w_unused  = &{1'b0, bus.data_addr_i[1:0]};

  assign w_sel_tx = w_mmio & w_page_ok & (w_off == 6'd0);
  assign w_sel_st = w_mmio & w_page_ok & (w_off == 6'd1);
  assign w_sel_cy = w_mmio & w_page_ok & (w_off == 6'd2);
  assign w_rd     = bus.data_ce_i & ~bus.data_we_i;
  assign w_wr     = bus.data_ce_i &  bus.data_we_i;
  assign w_bad    = bus.data_ce_i & (w_mmio ? ~(w_sel_tx | w_sel_st | w_sel_cy) : w_ram_oor);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_full     = r_cnt == CW'(FIFO_DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_pop      = ~w_empty & bus.tx_ready_i;
  assign w_push_req = w_wr & w_sel_tx;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr && !w_mmio && !w_ram_oor) r_ram[w_idx] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_drop  <= '0;
      r_cycle <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= bus.data_i[7:0];
        r_wr         <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_wr && w_sel_st)             r_drop <= '0;
      else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_wr && w_sel_cy) r_cycle <= bus.data_i;
      else                  r_cycle <= r_cycle + 32'd1;
      if (w_bad) r_err <= 1'b1;
    end
  end

  // Loads read pre-edge state; stores are never forwarded.
  always_comb begin
    bus.data_o = '0;
    if (w_rd) begin
      if (!w_mmio && !w_ram_oor) bus.data_o = r_ram[w_idx];
      else if (w_sel_st)         bus.data_o = {16'b0, r_drop, 2'b0, w_full, w_empty, r_cnt[3:0]};
      else if (w_sel_cy)         bus.data_o = r_cycle;
    end
  end

  assign bus.tx_valid_o = ~w_empty;
  assign bus.tx_data_o  = r_fifo[r_rd];
  assign err_o          = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus hand sequences for
// async reset mid-drain, bad MMIO offset and drop-counter saturation.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int   n_vec = 0;
  int   n_bad = 0;

  dmem_responder_if bus_if();

  dmem_responder #(.RAM_WORDS(1024), .FIFO_DEPTH(4), .MMIO_NIBBLE(4'h8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic [31:0] x_do;
    logic        x_v;
    logic [7:0]  x_tx;
    logic        x_err;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    bus_if.data_ce_i   = ce;
    bus_if.data_we_i   = we;
    bus_if.data_addr_i = a;
    bus_if.data_i      = d;
    bus_if.tx_ready_i  = rdy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ce, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic rdy, input logic [31:0] x_do, input logic x_v,
                     input logic [7:0] x_tx, input logic x_err);
    vec_t v;
    v.ce = ce; v.we = we; v.a = a; v.d = d; v.rdy = rdy;
    v.x_do = x_do; v.x_v = x_v; v.x_tx = x_tx; v.x_err = x_err;
    vt.push_back(v);
  endtask

  localparam logic [31:0] TXD = 32'h8000_0000;
  localparam logic [31:0] STA = 32'h8000_0004;
  localparam logic [31:0] CYC = 32'h8000_0008;

  initial begin
    //  ce we addr          wdata          rdy  data_o        v  tx     err
    add(1, 1, 32'h10,       32'hDEADBEEF,  0,   32'h0,        0, 8'h00, 0);
    add(1, 0, 32'h10,       32'h0,         0,   32'hDEADBEEF, 0, 8'h00, 0);
    add(1, 0, 32'h13,       32'h0,         0,   32'hDEADBEEF, 0, 8'h00, 0);
    add(1, 1, 32'h10,       32'h12345678,  0,   32'h0,        0, 8'h00, 0);
    add(1, 0, 32'h10,       32'h0,         0,   32'h12345678, 0, 8'h00, 0);
    add(1, 1, 32'h0,        32'h11111111,  0,   32'h0,        0, 8'h00, 0);
    add(1, 1, 32'h1000,     32'hCAFEF00D,  0,   32'h0,        0, 8'h00, 0);
    add(1, 0, 32'h1000,     32'h0,         0,   32'h0,        0, 8'h00, 1);
    add(1, 0, 32'h0,        32'h0,         0,   32'h11111111, 0, 8'h00, 1);
    add(1, 0, 32'h10,       32'h0,         0,   32'h12345678, 0, 8'h00, 1);
    add(1, 1, TXD,          32'h41,        0,   32'h0,        0, 8'h00, 1);
    add(1, 1, TXD,          32'h42,        0,   32'h0,        1, 8'h41, 1);
    add(1, 1, TXD,          32'h43,        0,   32'h0,        1, 8'h41, 1);
    add(1, 1, TXD,          32'h44,        0,   32'h0,        1, 8'h41, 1);
    add(1, 1, TXD,          32'h45,        0,   32'h0,        1, 8'h41, 1);
    add(1, 0, STA,          32'h0,         0,   32'h124,      1, 8'h41, 1);
    add(1, 0, TXD,          32'h0,         0,   32'h0,        1, 8'h41, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h41, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h42, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h43, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h44, 1);
    add(1, 0, STA,          32'h0,         1,   32'h110,      0, 8'h00, 1);
    add(1, 1, STA,          32'h0,         0,   32'h0,        0, 8'h00, 1);
    add(1, 1, TXD,          32'h51,        0,   32'h0,        0, 8'h00, 1);
    add(1, 1, TXD,          32'h52,        0,   32'h0,        1, 8'h51, 1);
    add(1, 1, TXD,          32'h53,        0,   32'h0,        1, 8'h51, 1);
    add(1, 1, TXD,          32'h54,        0,   32'h0,        1, 8'h51, 1);
    add(1, 1, TXD,          32'h55,        1,   32'h0,        1, 8'h51, 1);
    add(1, 0, STA,          32'h0,         0,   32'h024,      1, 8'h52, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h52, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h53, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h54, 1);
    add(0, 0, 32'h0,        32'h0,         1,   32'h0,        1, 8'h55, 1);
    add(1, 0, STA,          32'h0,         0,   32'h010,      0, 8'h00, 1);
    add(1, 1, CYC,          32'hFFFFFFFE,  0,   32'h0,        0, 8'h00, 1);
    add(1, 0, CYC,          32'h0,         0,   32'hFFFFFFFE, 0, 8'h00, 1);
    add(1, 0, CYC,          32'h0,         0,   32'hFFFFFFFF, 0, 8'h00, 1);
    add(1, 0, CYC,          32'h0,         0,   32'h00000000, 0, 8'h00, 1);
    add(1, 0, 32'h8000_000C, 32'h0,        0,   32'h0,        0, 8'h00, 1);
    add(1, 0, 32'h8000_0006, 32'h0,        0,   32'h010,      0, 8'h00, 1);

    drive(0, 0, 32'h0, 32'h0, 0);
    #2;
    chk("rst tx_valid", 32'(bus_if.tx_valid_o), 32'h0);
    chk("rst tx_data",  32'(bus_if.tx_data_o),  32'h0);
    chk("rst err",      32'(err),               32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    foreach (vt[i]) begin
      drive(vt[i].ce, vt[i].we, vt[i].a, vt[i].d, vt[i].rdy);
      #2;
      chk($sformatf("v%0d data_o", i), bus_if.data_o, vt[i].x_do);
      chk($sformatf("v%0d tx_valid", i), 32'(bus_if.tx_valid_o), 32'(vt[i].x_v));
      if (vt[i].x_v) chk($sformatf("v%0d tx_data", i), 32'(bus_if.tx_data_o), 32'(vt[i].x_tx));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vt[i].x_err));
      tick();
    end

    // Async reset with three bytes queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, TXD, 32'h61 + 32'(k), 0);
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst tx_valid", 32'(bus_if.tx_valid_o), 32'h0);
    chk("midrst tx_data",  32'(bus_if.tx_data_o),  32'h0);
    chk("midrst err",      32'(err),               32'h0);
    #1 rst_n = 1'b1;
    drive(1, 0, STA, 32'h0, 0);
    #1;
    chk("midrst status", bus_if.data_o, 32'h010);
    chk("midrst err after", 32'(err), 32'h0);
    tick();

    // Non-zero page bits make an MMIO access illegal
    drive(1, 0, 32'h8000_0100, 32'h0, 0);
    #2;
    chk("badpage data_o", bus_if.data_o, 32'h0);
    chk("badpage err pre", 32'(err), 32'h0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0);
    #2;
    chk("badpage err post", 32'(err), 32'h1);
    tick();

    // 264 pushes with no drain: 4 stored, drop count saturates at 255
    for (int k = 0; k < 264; k++) begin
      drive(1, 1, TXD, 32'(k), 0);
      tick();
    end
    drive(1, 0, STA, 32'h0, 0);
    #2;
    chk("drop saturate", bus_if.data_o, 32'h0000_FF24);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
